fetch_unit: RTL and testbench

//  Instruction-fetch stage. Owns the PC and issues word requests to instruction memory.

---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_buffer.sv | 65 ++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants, also used by decode and the immediate generator.
package fetch_unit_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam int              DEPTH_DEFAULT    = 2;

    // Major opcodes that decode and the immediate generator branch on.
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [1:0] {
        ENTRY_FREE,
        ENTRY_PENDING,
        ENTRY_FILLED
    } entry_state_e;

    typedef struct packed {
        entry_state_e    state;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and decode handshake.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_opcode;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               id_ready
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_opcode,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               id_ready
    );

endinterface

// File: rtl/fetch_unit_buffer.sv
// In-order fetch buffer. Each slot walks FREE -> PENDING -> FILLED -> FREE.
// tail allocates on request accept, fill points at the oldest PENDING slot,
// head is the slot presented to decode. Alloc, fill and pop always target slots
// in different states, so all three can land in the same cycle.
module fetch_unit_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic            tail_free_o,
    output fetch_entry_t    head_o
);

    localparam int PW = $clog2(DEPTH);

    localparam fetch_entry_t ENTRY_CLEAR = '{state: ENTRY_FREE, pc: '0, instr: '0};

    fetch_entry_t   entries_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [PW-1:0]  fill_q;

    // Slot state and pointer updates; reset and redirect flush empty the buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= ENTRY_CLEAR;
            end
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            if (alloc_i) begin
                entries_q[tail_q].state <= ENTRY_PENDING;
                entries_q[tail_q].pc    <= alloc_pc_i;
                entries_q[tail_q].instr <= '0;
                tail_q                  <= tail_q + PW'(1);
            end
            if (fill_i) begin
                entries_q[fill_q].state <= ENTRY_FILLED;
                entries_q[fill_q].instr <= fill_data_i;
                fill_q                  <= fill_q + PW'(1);
            end
            if (pop_i) begin
                entries_q[head_q].state <= ENTRY_FREE;
                head_q                  <= head_q + PW'(1);
            end
        end
    end

    // Registered-only view for issue gating and the decode outputs.
    always_comb begin
        tail_free_o = (entries_q[tail_q].state == ENTRY_FREE);
        head_o      = entries_q[head_q];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests, tracks responses
// still owed by memory and discards the ones that belong to a flushed path.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            reset_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            tail_free;
    fetch_entry_t    head_entry;
    logic            req_valid;
    logic            accept;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            pop;
    logic            head_filled;

    fetch_unit_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (bus.redirect_valid),
        .alloc_i     (accept),
        .alloc_pc_i  (pc_q),
        .fill_i      (rsp_fill),
        .fill_data_i (bus.imem_rsp_data),
        .pop_i       (pop),
        .tail_free_o (tail_free),
        .head_o      (head_entry)
    );

    // Issue, response routing and pop qualification. Issue is also held off
    // while DEPTH responses are still owed (possible after a redirect leaves
    // responses to drop) so the counters never pass DEPTH.
    always_comb begin
        head_filled = (head_entry.state == ENTRY_FILLED);
        req_valid   = !reset && !reset_q && tail_free && !bus.redirect_valid
                      && (inflight_q < CW'(DEPTH));
        accept      = req_valid && bus.imem_req_ready;
        rsp_drop    = bus.imem_rsp_valid && (drop_cnt_q != '0);
        rsp_fill    = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
        pop         = head_filled && bus.id_ready && !bus.redirect_valid;
    end

    // Next PC and counters; a redirect turns every owed response into a drop.
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight_d = inflight_q - CW'(bus.imem_rsp_valid);
            drop_cnt_d = inflight_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + XLEN'(4);
            end
            inflight_d = inflight_q + CW'(accept) - CW'(bus.imem_rsp_valid);
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Delayed reset keeps the request port quiet for the first cycle out of reset.
    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    // Decode sees registered buffer state only.
    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = pc_q;
        bus.id_valid       = head_filled;
        bus.id_instr       = head_entry.instr;
        bus.id_pc          = head_entry.pc;
        bus.id_opcode      = opcode_of(head_entry.instr);
    end

`ifndef SYNTHESIS
    rsp_needs_inflight: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_rsp_valid && (inflight_q == '0)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset state, a directed vector table, redirect/reset
// corner sequences, and a randomized run against an address-stream model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        o_reqv;
    logic [31:0] o_addr;
    logic        o_idv;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic [6:0]  o_opc;

    typedef struct {
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        redv;
        logic [31:0] redpc;
        logic        idr;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] rspd,
                                input logic redv, input logic [31:0] redpc, input logic idr,
                                input logic e_reqv, input logic [31:0] e_addr,
                                input logic e_idv, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.redv = redv; v.redpc = redpc;
        v.idr = idr; v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_idv = e_idv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample();
        o_reqv  = bus.imem_req_valid;
        o_addr  = bus.imem_req_addr;
        o_idv   = bus.id_valid;
        o_pc    = bus.id_pc;
        o_instr = bus.id_instr;
        o_opc   = bus.id_opcode;
    endtask

    task automatic cyc(input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic redv, input logic [31:0] redpc, input logic idr);
        @(posedge clk);
        #1;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rspd;
        bus.redirect_valid = redv;
        bus.redirect_pc    = redpc;
        bus.id_ready       = idr;
        @(negedge clk);
        sample();
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rst_reqv_in_reset", bus.imem_req_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        sample();
        chk("rst_reqv", o_reqv, 1'b0);
        chk("rst_idv", o_idv, 1'b0);
        chk("rst_idpc", o_pc, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rdy, tbl[i].rspv, tbl[i].rspd, tbl[i].redv, tbl[i].redpc, tbl[i].idr);
            chk($sformatf("vec%0d_reqv", i), o_reqv, tbl[i].e_reqv);
            if (tbl[i].e_reqv) chk($sformatf("vec%0d_addr", i), o_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_idv", i), o_idv, tbl[i].e_idv);
            if (tbl[i].e_idv) begin
                chk($sformatf("vec%0d_idpc", i), o_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d_instr", i), o_instr, mem_word(tbl[i].e_pc));
            end
        end
    endtask

    // Two requests outstanding when the redirect hits; both answers must be discarded.
    task automatic seq_redirect_inflight();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 1);                 chk("s3_addr0", o_addr, 32'h0);
        cyc(1, 1, mem_word(0), 0, 0, 1);       chk("s3_addr4", o_addr, 32'h4);
        cyc(1, 1, mem_word(4), 0, 0, 1);       chk("s3_pc0", o_pc, 32'h0);
        cyc(1, 0, 0, 0, 0, 1);                 chk("s3_addr8", o_addr, 32'h8);
        cyc(1, 0, 0, 0, 0, 1);                 chk("s3_addr12", o_addr, 32'hC);
                                               chk("s3_reqv12", o_reqv, 1'b1);
        cyc(1, 0, 0, 1, 32'h100, 1);           chk("s3_redir_noreq", o_reqv, 1'b0);
        cyc(1, 1, mem_word(8), 0, 0, 1);       chk("s3_drop8_idv", o_idv, 1'b0);
        cyc(1, 1, mem_word(12), 0, 0, 1);      chk("s3_drop12_idv", o_idv, 1'b0);
                                               chk("s3_addr100", o_addr, 32'h100);
                                               chk("s3_reqv100", o_reqv, 1'b1);
        cyc(1, 1, mem_word(32'h100), 0, 0, 1); chk("s3_idv_wait", o_idv, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);                 chk("s3_idv", o_idv, 1'b1);
                                               chk("s3_idpc", o_pc, 32'h100);
                                               chk("s3_instr", o_instr, mem_word(32'h100));
                                               chk("s3_opc", o_opc, mem_word(32'h100) & 32'h7F);
    endtask

    // Redirect in the same cycle as a response; the unaligned target is word-aligned.
    task automatic seq_redirect_with_rsp();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);                 chk("s4_addr0", o_addr, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);                 chk("s4_hold", o_addr, 32'h4);
        cyc(1, 1, mem_word(0), 1, 32'h203, 0); chk("s4_noreq", o_reqv, 1'b0);
        cyc(1, 0, 0, 0, 0, 1);                 chk("s4_reqv", o_reqv, 1'b1);
                                               chk("s4_addr200", o_addr, 32'h200);
                                               chk("s4_idv0", o_idv, 1'b0);
        cyc(0, 1, mem_word(32'h200), 0, 0, 1); chk("s4_idv_wait", o_idv, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);                 chk("s4_idpc", o_pc, 32'h200);
                                               chk("s4_instr", o_instr, mem_word(32'h200));
    endtask

    // Reset with both slots holding instructions.
    task automatic seq_reset_full();
        reset_dut();
        cyc(1, 0, 0, 0, 0, 0);           chk("s6_addr0", o_addr, 32'h0);
        cyc(1, 1, mem_word(0), 0, 0, 0); chk("s6_addr4", o_addr, 32'h4);
        cyc(1, 1, mem_word(4), 0, 0, 0); chk("s6_full_noreq", o_reqv, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);           chk("s6_idv_full", o_idv, 1'b1);
                                         chk("s6_idpc_full", o_pc, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("s6_reqv_in_reset", bus.imem_req_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        sample();
        chk("s6_idv_after", o_idv, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);           chk("s6_resume", o_reqv, 1'b1);
                                         chk("s6_resume_addr", o_addr, RESET_PC);
    endtask

    // Random traffic: the model only knows the architectural streams. Requests
    // go out at sequential word addresses from the last target, decode receives
    // sequential PCs with the memory's word for each, and nothing from a flushed
    // path ever reaches decode.
    task automatic run_random(input int ncyc);
        mem_t        mq[$];
        logic [31:0] exp_issue;
        logic [31:0] exp_id;
        int          last_due;
        int          pops;
        exp_issue = RESET_PC;
        exp_id    = RESET_PC;
        last_due  = 0;
        pops      = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic        rdy, rspv, redv, idr;
            logic [31:0] rspd, redpc;
            int          due;
            rdy   = ($urandom_range(0, 3) != 0);
            idr   = ($urandom_range(0, 3) != 0);
            redv  = ($urandom_range(0, 24) == 0);
            redpc = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            rspv  = (mq.size() > 0) && (mq[0].due <= c);
            rspd  = rspv ? mem_word(mq[0].addr) : 32'h0;
            cyc(rdy, rspv, rspd, redv, redpc, idr);
            if (rspv) void'(mq.pop_front());
            if (o_reqv && rdy) begin
                chk("rnd_addr", o_addr, exp_issue);
                due = c + 1 + $urandom_range(0, 3);
                if (due < last_due) due = last_due;
                last_due = due;
                mq.push_back('{addr: o_addr, due: due});
                exp_issue = exp_issue + 32'd4;
            end
            if (o_idv && idr) begin
                chk("rnd_idpc", o_pc, exp_id);
                chk("rnd_instr", o_instr, mem_word(exp_id));
                chk("rnd_opc", o_opc, mem_word(exp_id) & 32'h7F);
                exp_id = exp_id + 32'd4;
                pops++;
            end
            if (redv) begin
                chk("rnd_redir_noreq", o_reqv, 1'b0);
                exp_issue = {redpc[31:2], 2'b00};
                exp_id    = {redpc[31:2], 2'b00};
            end
            chk("rnd_outstanding", (mq.size() <= DEPTH), 1'b1);
        end
        chk("rnd_progress", (pops > ncyc / 10), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();

        // Straight-line fetch, decode stall, request back-pressure, redirect to 0x203.
        tbl.push_back(mk(1, 0, 0,                0, 0,       1, 1, 32'h0,   0, 0));
        tbl.push_back(mk(1, 1, mem_word(0),      0, 0,       1, 1, 32'h4,   0, 0));
        tbl.push_back(mk(1, 1, mem_word(4),      0, 0,       1, 0, 0,       1, 32'h0));
        tbl.push_back(mk(1, 0, 0,                0, 0,       1, 1, 32'h8,   1, 32'h4));
        tbl.push_back(mk(1, 1, mem_word(8),      0, 0,       1, 1, 32'hC,   0, 0));
        tbl.push_back(mk(1, 1, mem_word(12),     0, 0,       1, 0, 0,       1, 32'h8));
        tbl.push_back(mk(1, 0, 0,                0, 0,       0, 1, 32'h10,  1, 32'hC));
        tbl.push_back(mk(1, 1, mem_word(16),     0, 0,       0, 0, 0,       1, 32'hC));
        tbl.push_back(mk(1, 0, 0,                0, 0,       0, 0, 0,       1, 32'hC));
        tbl.push_back(mk(1, 0, 0,                0, 0,       0, 0, 0,       1, 32'hC));
        tbl.push_back(mk(1, 0, 0,                0, 0,       0, 0, 0,       1, 32'hC));
        tbl.push_back(mk(1, 0, 0,                0, 0,       1, 0, 0,       1, 32'hC));
        tbl.push_back(mk(1, 0, 0,                0, 0,       1, 1, 32'h14,  1, 32'h10));
        tbl.push_back(mk(0, 1, mem_word(20),     0, 0,       1, 1, 32'h18,  0, 0));
        tbl.push_back(mk(0, 0, 0,                0, 0,       1, 1, 32'h18,  1, 32'h14));
        tbl.push_back(mk(0, 0, 0,                0, 0,       1, 1, 32'h18,  0, 0));
        tbl.push_back(mk(1, 0, 0,                0, 0,       1, 1, 32'h18,  0, 0));
        tbl.push_back(mk(0, 1, mem_word(24),     0, 0,       1, 1, 32'h1C,  0, 0));
        tbl.push_back(mk(1, 0, 0,                1, 32'h203, 0, 0, 0,       1, 32'h18));
        tbl.push_back(mk(1, 0, 0,                0, 0,       1, 1, 32'h200, 0, 0));
        tbl.push_back(mk(0, 1, mem_word(32'h200), 0, 0,      1, 1, 32'h204, 0, 0));
        tbl.push_back(mk(0, 0, 0,                0, 0,       1, 1, 32'h204, 1, 32'h200));

        reset_dut();
        run_table();
        seq_redirect_inflight();
        seq_redirect_with_rsp();
        seq_reset_full();
        reset_dut();
        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
